// File: rtl/conv_enc_pkg.sv
// Shared definitions for the convolutional-encoder block scheduler.
// Holds the scheduler FSM encoding, block sizes in bytes, encoder startup
// blanking length and the per-block context latched at grant time.
package conv_enc_pkg;

    localparam int NUM_REQ         = 2;
    localparam int BYTE_W          = 8;
    localparam int CNT_W           = 11;   // holds LARGE_BYTES
    localparam int SMALL_BYTES     = 132;  // 1056 bits
    localparam int LARGE_BYTES     = 768;  // 6144 bits
    localparam int ENC_STARTUP_CYC = 2;
    localparam int RD_LAT          = 1;    // encoder output FIFO read latency

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_ENCODE,
        ST_DRAIN
    } sched_state_e;

    typedef struct packed {
        logic              len;
        logic [BYTE_W-1:0] tail;
        logic              src;
    } blk_ctx_t;

    function automatic logic [CNT_W-1:0] blk_bytes(input logic len);
        return len ? CNT_W'(LARGE_BYTES) : CNT_W'(SMALL_BYTES);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   req        : request vector
//   accept     : the current grant is taken; priority moves past the winner
//   grant      : one-hot grant, 0 when nothing requests
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic ptr;   // requester currently holding priority
    logic other;

    assign other = ~ptr;

    always_comb begin
        grant = 2'b00;
        if (req[ptr])        grant[ptr]   = 1'b1;
        else if (req[other]) grant[other] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)                 ptr <= 1'b0;
        else if (accept && |grant) ptr <= ~grant[1];
    end
endmodule

// File: rtl/conv_enc_sched.sv
// Schedules code blocks from two requesters onto one shared encoder, then
// drains the encoder's output FIFOs to a downstream byte stream.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   req/req_len/req_tail : per-requester ready flag, size select, tail byte
//   src_*                : per-requester block FIFO, muxed to the encoder
//   grant                : one-hot current owner of the encoder
//   enc_*                : encoder handshake (block ready, len, tail, data)
//   drain_rdreq          : read strobe to the encoder output FIFOs
//   out_valid/last/src   : output byte qualifiers, out_ready from downstream
//   busy                 : FSM not idle
// Optional: CONV_SCHED_STATS_EN adds blk_cnt0/blk_cnt1 completed-block counts.
module conv_enc_sched
    import conv_enc_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_len,
    input  logic [NUM_REQ-1:0][BYTE_W-1:0]  req_tail,
    input  logic [NUM_REQ-1:0][BYTE_W-1:0]  src_data,
    input  logic [NUM_REQ-1:0]              src_empty,
    output logic [NUM_REQ-1:0]              src_rdreq,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            enc_blk_ready,
    output logic                            enc_len,
    output logic [BYTE_W-1:0]               enc_tail,
    output logic [BYTE_W-1:0]               enc_blk_data,
    output logic                            enc_blk_empty,
    input  logic                            enc_blk_rdreq,
    input  logic                            enc_done,
    output logic                            drain_rdreq,
    output logic                            out_valid,
    output logic                            out_last,
    output logic                            out_src,
    input  logic                            out_ready,
    output logic                            busy
`ifdef CONV_SCHED_STATS_EN
    ,
    output logic [15:0]                     blk_cnt0,
    output logic [15:0]                     blk_cnt1
`endif
);
    sched_state_e         state, state_nxt;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [NUM_REQ-1:0]   grant_q;
    blk_ctx_t             ctx_q;
    logic [1:0]           su_cnt;
    logic                 su_done;
    logic [CNT_W-1:0]     byte_cnt;
    logic [RD_LAT:1]      vld_pipe;
    logic [RD_LAT:1]      last_pipe;
    logic                 win;
    logic                 take;

    assign take = (state == ST_IDLE) && |req;
    assign win  = arb_gnt[1];

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (take),
        .grant  (arb_gnt)
    );

    // Encoder may leave enc_done high from the previous block; blank it
    // until it has had ENC_STARTUP_CYC cycles to clear.
    assign su_done = (su_cnt == 2'(ENC_STARTUP_CYC));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|req)               state_nxt = ST_START;
            ST_START:                          state_nxt = ST_ENCODE;
            ST_ENCODE: if (su_done && enc_done) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (out_last)           state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    assign busy          = (state != ST_IDLE);
    assign enc_blk_ready = (state == ST_START);
    assign drain_rdreq   = (state == ST_DRAIN) && out_ready && (byte_cnt != '0);
    assign out_valid     = vld_pipe[RD_LAT];
    assign out_last      = last_pipe[RD_LAT];
    assign grant         = grant_q;
    assign enc_len       = ctx_q.len;
    assign enc_tail      = ctx_q.tail;
    assign out_src       = ctx_q.src;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q   <= '0;
            ctx_q     <= '0;
            su_cnt    <= '0;
            byte_cnt  <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            // Output FIFO read latency: qualifiers trail the strobe.
            vld_pipe  <= (vld_pipe << 1)  | RD_LAT'(drain_rdreq);
            last_pipe <= (last_pipe << 1) | RD_LAT'(drain_rdreq && byte_cnt == CNT_W'(1));
            case (state)
                ST_IDLE: if (take) begin
                    grant_q <= arb_gnt;
                    ctx_q   <= '{len: req_len[win], tail: req_tail[win], src: win};
                end
                ST_START: su_cnt <= '0;
                ST_ENCODE: begin
                    if (!su_done) su_cnt <= su_cnt + 2'd1;
                    if (state_nxt == ST_DRAIN) byte_cnt <= blk_bytes(ctx_q.len);
                end
                ST_DRAIN: begin
                    if (drain_rdreq) byte_cnt <= byte_cnt - CNT_W'(1);
                    if (out_last)    grant_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Block-FIFO path follows the latched owner; parked when nobody owns it.
    always_comb begin
        enc_blk_data  = '0;
        enc_blk_empty = 1'b1;
        src_rdreq     = '0;
        if (|grant_q) begin
            enc_blk_data           = src_data[ctx_q.src];
            enc_blk_empty          = src_empty[ctx_q.src];
            src_rdreq[ctx_q.src]   = enc_blk_rdreq;
        end
    end

`ifdef CONV_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt0 <= '0;
            blk_cnt1 <= '0;
        end else if (out_last) begin
            if (ctx_q.src) blk_cnt1 <= blk_cnt1 + 16'd1;
            else           blk_cnt0 <= blk_cnt0 + 16'd1;
        end
    end
`endif
endmodule

// File: doc/conv_enc_sched.md
CONV_ENC_SCHED -- requirements
Module: conv_enc_sched

Interface
REQ-001 SHALL have port: clk  in  1  clock; all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: req  in  2  per-requester code-block-ready flag; bit i is requester i.
REQ-004 SHALL have port: req_len  in  2  per-requester length select: 1 = large, 6144 bits / 768 bytes; 0 = small, 1056 bits / 132 bytes.
REQ-005 SHALL have port: req_tail  in  16  per-requester tail byte, {req1, req0}.
REQ-006 SHALL have port: src_data  in  16  per-requester block-FIFO data, {req1, req0}.
REQ-007 SHALL have port: src_empty  in  2  per-requester block-FIFO empty.
REQ-008 SHALL have port: src_rdreq  out  2  per-requester block-FIFO read request.
REQ-009 SHALL have port: grant  out  2  one-hot owner of the encoder; 0 when none.
REQ-010 SHALL have ports: enc_blk_ready out 1; enc_len out 1; enc_tail out 8; enc_blk_data out 8; enc_blk_empty out 1. All drive the encoder.
REQ-011 SHALL have ports: enc_blk_rdreq in 1 and enc_done in 1, both from the encoder.
REQ-012 SHALL have port: drain_rdreq  out  1  read strobe to the encoder's three output FIFOs.
REQ-013 SHALL have ports: out_valid out 1; out_last out 1; out_src out 1 (requester index); out_ready in 1 (downstream can take the next byte).
REQ-014 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> START -> ENCODE -> DRAIN -> IDLE.
REQ-016 IDLE SHALL stay in IDLE while req == 0.
REQ-017 On any req bit in IDLE, the block SHALL pick a winner by round-robin (requester i wins, then i+1 has priority), latch its len/tail, set grant, and move to START.
REQ-018 START SHALL hold enc_blk_ready high for exactly one cycle and then move to ENCODE.
REQ-019 In ENCODE, enc_done SHALL be ignored for the first 2 cycles (encoder startup); after that, enc_done = 1 SHALL move to DRAIN.
REQ-020 While grant is nonzero, enc_blk_data and enc_blk_empty SHALL be combinational muxes of the granted source, and src_rdreq[g] = enc_blk_rdreq; other src_rdreq bits SHALL be 0.
REQ-021 While grant == 0, enc_blk_empty SHALL be 1, enc_blk_data 0, and src_rdreq 0.
REQ-022 enc_len and enc_tail SHALL hold the latched values from grant until return to IDLE; req changes mid-block SHALL have no effect.
REQ-023 DRAIN: an 11-bit down-counter SHALL load 768 or 132 on DRAIN entry.
REQ-024 DRAIN: drain_rdreq = out_ready AND counter != 0; each strobe SHALL decrement the counter.
REQ-025 out_valid SHALL assert exactly 1 cycle after each drain_rdreq (FIFO read latency 1); downstream SHALL accept every out_valid.
REQ-026 out_last SHALL accompany the final out_valid; out_src = latched winner.
REQ-027 The cycle after out_last, the FSM SHALL return to IDLE and grant SHALL clear.
REQ-028 Simultaneous req = 2'b11 in IDLE SHALL grant the round-robin holder; the loser SHALL be served next provided it is still requesting.

Reset
REQ-029 Reset SHALL force: state IDLE; grant 0; enc_blk_ready 0; drain_rdreq 0; out_valid/out_last 0; counter 0; RR pointer to requester 0; busy 0.
REQ-030 Reset mid-ENCODE or mid-DRAIN SHALL abort the block; no further out_valid; src FIFOs are not flushed.

Configuration
REQ-031 With CONV_SCHED_STATS_EN defined: ports blk_cnt0 and blk_cnt1 (out, 16 each) SHALL count completed blocks per requester, incremented on out_last, wrapping at 16'hFFFF -> 0, cleared by reset.
REQ-032 Without CONV_SCHED_STATS_EN, those ports and counters SHALL NOT exist.

Structure
REQ-033 A shared package conv_enc_pkg SHALL hold the FSM state enum, SMALL_BYTES = 132, LARGE_BYTES = 768, and ENC_STARTUP_CYC = 2.
REQ-034 The round-robin picker SHALL be one sub-module, rr_arb2: request in, one-hot grant out, pointer update on accept.

Verification
REQ-035 req = 01, len 0, tail 8'hA5 -> grant = 01; one-cycle enc_blk_ready; enc_tail = A5; enc_done -> exactly 132 out_valid, out_last on the 132nd, out_src = 0.
REQ-036 req = 11 from reset -> requester 0 is served first with 768 bytes (len 1), then requester 1; grant never 11.
REQ-037 out_ready toggling 1010... during DRAIN -> drain_rdreq only on high cycles; total out_valid count is still exact; out_last is still single.
REQ-038 enc_done held high during START and the first 2 ENCODE cycles -> no DRAIN entry until the 3rd ENCODE cycle.
REQ-039 Reset asserted at DRAIN byte 50 -> the next cycle has busy = 0, out_valid = 0, grant = 0; the next req restarts cleanly.
REQ-040 With CONV_SCHED_STATS_EN: 3 blocks from req0 and 1 from req1 -> blk_cnt0 = 3, blk_cnt1 = 1.
